// File: rtl/operand_regfile.sv
// Integer register file with a pending-write scoreboard and registered operand issue to the ALU.
// Optional same-cycle write-back forwarding is enabled by defining OPERAND_REGFILE_BYPASS_EN.
module operand_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            iss_valid,
   output logic            iss_ready,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   input  logic [AW-1:0]   rd_addr,
   input  logic            rd_en,
   output logic            op_valid,
   output logic [XLEN-1:0] busA,
   output logic [XLEN-1:0] busB,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   output logic [NREG-1:0] pending
);

`ifdef OPERAND_REGFILE_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] pending_q, pending_d;
   logic [XLEN-1:0] busa_q, busa_d;
   logic [XLEN-1:0] busb_q, busb_d;
   logic            op_valid_q, op_valid_d;

   logic            fwd1, fwd2;
   logic            hzd1, hzd2;
   logic            accept;
   logic [XLEN-1:0] opa, opb;

   always_comb begin
      fwd1      = BYPASS && wr_en && (wr_addr == rs1_addr);
      fwd2      = BYPASS && wr_en && (wr_addr == rs2_addr);
      hzd1      = (rs1_addr != '0) && pending_q[rs1_addr] && !fwd1;
      hzd2      = (rs2_addr != '0) && pending_q[rs2_addr] && !fwd2;
      iss_ready = !(hzd1 || hzd2);
      accept    = iss_valid && iss_ready;

      if (rs1_addr == '0)  opa = '0;
      else if (fwd1)       opa = wr_data;
      else                 opa = regs_q[rs1_addr];

      if (rs2_addr == '0)  opb = '0;
      else if (fwd2)       opb = wr_data;
      else                 opb = regs_q[rs2_addr];
   end

   // Write-back clears first so a same-edge reservation of the same register wins.
   always_comb begin
      pending_d  = pending_q;
      busa_d     = busa_q;
      busb_d     = busb_q;
      op_valid_d = 1'b0;
      if (wr_en)
         pending_d[wr_addr] = 1'b0;
      if (accept) begin
         busa_d     = opa;
         busb_d     = opb;
         op_valid_d = 1'b1;
         if (rd_en && (rd_addr != '0))
            pending_d[rd_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= '0;
         pending_q  <= '0;
         busa_q     <= '0;
         busb_q     <= '0;
         op_valid_q <= 1'b0;
      end else begin
         if (wr_en && (wr_addr != '0))
            regs_q[wr_addr] <= wr_data;
         pending_q  <= pending_d;
         busa_q     <= busa_d;
         busb_q     <= busb_d;
         op_valid_q <= op_valid_d;
      end
   end

   assign busA     = busa_q;
   assign busB     = busb_q;
   assign op_valid = op_valid_q;
   assign pending  = pending_q;

endmodule

// File: tb/tb_operand_regfile.sv
// Self-checking bench for operand_regfile: directed scenarios followed by random traffic
// compared against an array-based reference model of the register file and scoreboard.
module tb_operand_regfile;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

`ifdef OPERAND_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk;
   logic            rst_n;
   logic            iss_valid;
   logic            iss_ready;
   logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr, wr_addr;
   logic            rd_en, wr_en;
   logic            op_valid;
   logic [XLEN-1:0] busA, busB, wr_data;
   logic [NREG-1:0] pending;

   operand_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rd_addr   (rd_addr),
      .rd_en     (rd_en),
      .op_valid  (op_valid),
      .busA      (busA),
      .busB      (busB),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   logic [XLEN-1:0] m_reg  [NREG];
   bit              m_pend [NREG];
   logic [XLEN-1:0] m_busa, m_busb;
   bit              m_opv;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_fwd(input int a);
      return BYP && wr_en && (int'(wr_addr) == a);
   endfunction

   function automatic logic [XLEN-1:0] m_value(input int a);
      if (a == 0)    return '0;
      if (m_fwd(a))  return wr_data;
      return m_reg[a];
   endfunction

   function automatic bit m_ready();
      bit h1, h2;
      h1 = (rs1_addr != 0) && m_pend[rs1_addr] && !m_fwd(int'(rs1_addr));
      h2 = (rs2_addr != 0) && m_pend[rs2_addr] && !m_fwd(int'(rs2_addr));
      return !(h1 || h2);
   endfunction

   function automatic logic [NREG-1:0] m_pend_vec();
      logic [NREG-1:0] v;
      for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NREG; i++) begin
         m_reg[i]  = '0;
         m_pend[i] = 1'b0;
      end
      m_busa = '0;
      m_busb = '0;
      m_opv  = 1'b0;
   endtask

   task automatic m_edge();
      bit acc;
      acc   = iss_valid && m_ready();
      m_opv = acc;
      if (acc) begin
         m_busa = m_value(int'(rs1_addr));
         m_busb = m_value(int'(rs2_addr));
      end
      if (wr_en) begin
         if (wr_addr != 0) m_reg[wr_addr] = wr_data;
         m_pend[wr_addr] = 1'b0;
      end
      if (acc && rd_en && rd_addr != 0) m_pend[rd_addr] = 1'b1;
   endtask

   task automatic check_outputs(input string where);
      check({where, ".op_valid"}, op_valid, m_opv);
      check({where, ".busA"},     busA,     m_busa);
      check({where, ".busB"},     busB,     m_busb);
      check({where, ".pending"},  pending,  m_pend_vec());
   endtask

   task automatic step(input string where);
      @(negedge clk);
      check({where, ".iss_ready"}, iss_ready, m_ready());
      @(posedge clk);
      m_edge();
      #1;
      check_outputs(where);
   endtask

   task automatic drive(input bit v, input int r1, input int r2, input bit rde, input int rd,
                        input bit we, input int wa, input logic [XLEN-1:0] wd);
      iss_valid = v;
      rs1_addr  = AW'(r1);
      rs2_addr  = AW'(r2);
      rd_en     = rde;
      rd_addr   = AW'(rd);
      wr_en     = we;
      wr_addr   = AW'(wa);
      wr_data   = wd;
   endtask

   initial begin
      m_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, '0);
      #3;
      check_outputs("reset");
      check("reset.iss_ready", iss_ready, 1);
      #9 rst_n = 1'b1;

      // zero operands
      drive(1, 0, 0, 0, 0, 0, 0, '0);
      step("zero");
      check("zero.busA_const", busA, 0);
      check("zero.opv_const", op_valid, 1);

      // write x5, x6 then read them
      drive(0, 0, 0, 0, 0, 1, 5, 32'h0000_00AA);
      step("wr5");
      drive(0, 0, 0, 0, 0, 1, 6, 32'h0000_0055);
      step("wr6");
      drive(1, 5, 6, 0, 0, 0, 0, '0);
      step("rd56");
      check("rd56.busA_const", busA, 32'hAA);
      check("rd56.busB_const", busB, 32'h55);
      drive(0, 0, 0, 0, 0, 0, 0, '0);
      step("rd56_pulse");
      check("rd56.opv_drop", op_valid, 0);

      // RAW on x7
      drive(1, 0, 0, 1, 7, 0, 0, '0);
      step("rsv7");
      drive(1, 7, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      check("raw7.stall", iss_ready, 0);
      check("raw7.pend", pending[7], 1);
      step("raw7_stall");
      drive(1, 7, 0, 0, 0, 1, 7, 32'h1234);
      step("raw7_wb");
      if (BYP) begin
         check("raw7.byp_busA", busA, 32'h1234);
         check("raw7.byp_opv", op_valid, 1);
      end else begin
         check("raw7.nobyp_opv", op_valid, 0);
         drive(1, 7, 0, 0, 0, 0, 0, '0);
         step("raw7_late");
         check("raw7.late_busA", busA, 32'h1234);
      end

      // register 0 is immutable and never pending
      drive(1, 0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF);
      step("x0_wr");
      check("x0.pend", pending[0], 0);
      drive(1, 0, 0, 0, 0, 0, 0, '0);
      step("x0_rd");
      check("x0.busA", busA, 0);

      // same-edge write and reservation of x9: set wins
      drive(1, 0, 0, 1, 9, 1, 9, 32'h99);
      step("x9_same");
      check("x9.pend", pending[9], 1);

      // reset while stalled on x3
      drive(1, 0, 0, 1, 3, 0, 0, '0);
      step("rsv3");
      drive(1, 3, 3, 0, 0, 0, 0, '0);
      step("stall3");
      check("stall3.opv", op_valid, 0);
      #3 rst_n = 1'b0;
      m_reset();
      #1;
      check_outputs("mid_reset");
      #2 rst_n = 1'b1;
      step("after_reset");
      check("after_reset.opv", op_valid, 1);
      check("after_reset.busA", busA, 0);

      // random traffic over a small register window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 3) != 0,
               $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1) == 1, $urandom_range(0, 7),
               $urandom_range(0, 2) == 0, $urandom_range(0, 7),
               $urandom());
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_regfile.md
Name: operand_regfile

Overview:
- Integer register file and operand issue stage; sits directly upstream of the execute ALU.
- Supplies registered busA/busB to the ALU and accepts the ALU result (busC) back on its write port.
- Holds a per-register pending-write scoreboard. It stalls issue of any operand read whose source register has a result still outstanding.

Parameters:
- XLEN, 32, data width of registers and buses.
- NREG, 32, number of architectural registers; register 0 hardwired to zero.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iss_valid  input  1  issue request: read rs1/rs2 and optionally reserve rd.
- iss_ready  output  1  issue accepted this cycle when iss_valid && iss_ready.
- rs1_addr  input  AW  source register 1.
- rs2_addr  input  AW  source register 2.
- rd_addr  input  AW  destination to mark pending on accept.
- rd_en  input  1  reserve rd_addr on accept.
- op_valid  output  1  busA/busB valid (one-cycle pulse per accepted issue).
- busA  output  XLEN  operand 1 to ALU.
- busB  output  XLEN  operand 2 to ALU.
- wr_en  input  1  write-back strobe from ALU result path.
- wr_addr  input  AW  write-back register.
- wr_data  input  XLEN  write-back data (ALU busC).
- pending  output  NREG  scoreboard bits, for debug and verification.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers, pending, busA, busB and op_valid clear to 0.
  - iss_ready is combinational and evaluates per the hazard rule with pending = 0.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - Its pending bit is never set, even with rd_en && rd_addr==0.
- Write port: on a rising edge with wr_en, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Hazard: hzd1 = rs1_addr!=0 && pending[rs1_addr] && !release1. hzd2 is the same for rs2.
  - release1 = wr_en && wr_addr==rs1_addr (only when BYPASS_EN is defined, else 0).
  - iss_ready = !(hzd1 || hzd2). rd is not checked (no WAW stall; in-order single write-back).
- Accept (iss_valid && iss_ready at an edge):
  - busA <= value(rs1), busB <= value(rs2), op_valid <= 1.
  - If rd_en && rd_addr!=0, pending[rd_addr] <= 1.
  - Latency: operands appear the cycle after accept.
- No accept: op_valid <= 0. busA/busB hold their previous values.
- Operand value: 0 if addr==0; else wr_data if the BYPASS_EN write-forward applies; else reg[addr].
- Simultaneous write clear and accept set on the same register in one edge: set wins (pending=1). The data write still occurs.
- Reset mid-stall: pending clears, so the stalled request is accepted on the first edge after rst_n deasserts (if still valid).
- Every accepted issue produces exactly one op_valid pulse. No internal queue; back-to-back accepts give back-to-back pulses.

Optional Feature:
- Macro: OPERAND_REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-back forwarding: read of wr_addr returns wr_data.
  - The matching pending bit is treated as released for the iss_ready computation.
  - A dependent instruction issues in the same cycle as its producer's write-back.
- Undefined:
  - Reads return the stored (old) register value.
  - The hazard releases only on the edge after the write.
  - Costs one extra stall cycle per RAW dependence.

Test Plan:
- Reset then issue rs1=0, rs2=0 -> iss_ready=1; next cycle op_valid=1, busA=0, busB=0, pending=0.
- Write x5=0x0000_00AA, x6=0x0000_0055; then issue rs1=5, rs2=6 -> next cycle busA=0xAA, busB=0x55, op_valid=1 for one cycle.
- Issue with rd_en, rd=7 (accepted); then issue rs1=7 -> iss_ready=0 and pending[7]=1. Write x7=0x1234 -> with BYPASS_EN accepted in the write cycle and busA=0x1234; without it, accepted the following cycle with busA=0x1234.
- Write x0=0xFFFF_FFFF and issue rd_en, rd=0 -> pending[0]=0; issue rs1=0 -> busA=0.
- Same edge: wr_en to x9, plus an accepted issue with rd_en, rd=9 -> x9 updated, pending[9]=1 afterwards.
- Hold a stalled request on pending x3 and pulse rst_n low mid-stall -> outputs 0, pending=0; request accepted on the first edge after release, busA=0 (x3 cleared).
